// File: rtl/axis_reg_array_param_pkg.sv
// Shared types for the AXI-Stream register array (lynxTypes).
package lynxTypes;

    typedef enum logic [0:0] {
        REG_MODE_FULL,
        REG_MODE_FWD
    } reg_mode_t;

endpackage

// File: rtl/axis_reg_array_param_slice.sv
// One AXI-Stream register stage: FULL = main+skid with registered tready,
// FWD = single entry with combinational tready. Payload is an opaque vector.
module axis_reg_slice_param
    import lynxTypes::*;
#(
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter reg_mode_t   MODE         = REG_MODE_FULL
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [PAYLOAD_BITS-1:0] s_tpayload,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [PAYLOAD_BITS-1:0] m_tpayload
);

    if (MODE == REG_MODE_FULL) begin : g_full
        logic                    main_vld_q, main_vld_d;
        logic                    skid_vld_q, skid_vld_d;
        logic                    rdy_q;
        logic [PAYLOAD_BITS-1:0] main_q, main_d, skid_q, skid_d;
        logic                    s_fire, m_fire;

        assign s_fire = s_tvalid && rdy_q;
        assign m_fire = main_vld_q && m_tready;

        // rdy_q tracks !skid, so a beat can only land in skid while it is empty
        always_comb begin
            main_vld_d = main_vld_q;
            skid_vld_d = skid_vld_q;
            main_d     = main_q;
            skid_d     = skid_q;
            if (skid_vld_q) begin
                if (m_fire) begin
                    main_d     = skid_q;
                    skid_vld_d = 1'b0;
                end
            end else if (!main_vld_q || m_fire) begin
                main_vld_d = s_fire;
                if (s_fire) main_d = s_tpayload;
            end else if (s_fire) begin
                skid_vld_d = 1'b1;
                skid_d     = s_tpayload;
            end
        end

        always_ff @(posedge aclk) begin
            if (areset) begin
                main_vld_q <= 1'b0;
                skid_vld_q <= 1'b0;
                rdy_q      <= 1'b0;
            end else begin
                main_vld_q <= main_vld_d;
                skid_vld_q <= skid_vld_d;
                rdy_q      <= !skid_vld_d;
            end
        end

        always_ff @(posedge aclk) begin
            main_q <= main_d;
            skid_q <= skid_d;
        end

        assign s_tready   = rdy_q;
        assign m_tvalid   = main_vld_q;
        assign m_tpayload = main_q;
    end else begin : g_fwd
        logic                    vld_q, vld_d;
        logic [PAYLOAD_BITS-1:0] pl_q, pl_d;

        assign s_tready = !areset && (!vld_q || m_tready);

        always_comb begin
            vld_d = vld_q;
            pl_d  = pl_q;
            if (s_tready) begin
                vld_d = s_tvalid;
                if (s_tvalid) pl_d = s_tpayload;
            end
        end

        always_ff @(posedge aclk) begin
            if (areset) vld_q <= 1'b0;
            else        vld_q <= vld_d;
        end

        always_ff @(posedge aclk) begin
            pl_q <= pl_d;
        end

        assign m_tvalid   = vld_q;
        assign m_tpayload = pl_q;
    end

endmodule

// File: rtl/axis_reg_array_param.sv
// Cascade of N_STAGES AXI-Stream register slices (0 = wire).
// Define REG_ARRAY_STATS_EN to add the occupancy and beat_cnt ports.
module axis_reg_array_param
    import lynxTypes::*;
#(
    parameter int unsigned N_STAGES  = 2,
    parameter int unsigned DATA_BITS = 512,
    parameter int unsigned ID_BITS   = 6,
    parameter reg_mode_t   MODE      = REG_MODE_FULL
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [DATA_BITS-1:0]   s_axis_tdata,
    input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic [ID_BITS-1:0]     s_axis_tid,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DATA_BITS-1:0]   m_axis_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic [ID_BITS-1:0]     m_axis_tid
`ifdef REG_ARRAY_STATS_EN
    ,
    output logic [((N_STAGES == 0) ? 1 : $clog2(2*N_STAGES+1))-1:0] occupancy,
    output logic [31:0]            beat_cnt
`endif
);

    localparam int unsigned PW = DATA_BITS + DATA_BITS/8 + 1 + ID_BITS;

    logic [PW-1:0] s_pl, m_pl;

    assign s_pl = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tid};
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid} = m_pl;

    if (N_STAGES == 0) begin : g_wire
        assign m_axis_tvalid = s_axis_tvalid;
        assign s_axis_tready = m_axis_tready;
        assign m_pl          = s_pl;
    end else begin : g_chain
        // Per-stage handshake nets live in each generate scope so the ready
        // chain is not one self-referencing vector.
        for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
            logic          in_vld, out_rdy, vld, rdy;
            logic [PW-1:0] in_pl, pl;

            if (i == 0) begin : g_first
                assign in_vld = s_axis_tvalid;
                assign in_pl  = s_pl;
            end else begin : g_mid
                assign in_vld = g_stage[i-1].vld;
                assign in_pl  = g_stage[i-1].pl;
            end

            if (i == N_STAGES - 1) begin : g_last
                assign out_rdy = m_axis_tready;
            end else begin : g_next
                assign out_rdy = g_stage[i+1].rdy;
            end

            axis_reg_slice_param #(
                .PAYLOAD_BITS(PW),
                .MODE        (MODE)
            ) u_slice (
                .aclk      (aclk),
                .areset    (areset),
                .s_tvalid  (in_vld),
                .s_tready  (rdy),
                .s_tpayload(in_pl),
                .m_tvalid  (vld),
                .m_tready  (out_rdy),
                .m_tpayload(pl)
            );
        end

        assign s_axis_tready = g_stage[0].rdy;
        assign m_axis_tvalid = g_stage[N_STAGES-1].vld;
        assign m_pl          = g_stage[N_STAGES-1].pl;
    end

`ifdef REG_ARRAY_STATS_EN
    localparam int unsigned OCC_W = (N_STAGES == 0) ? 1 : $clog2(2*N_STAGES+1);

    logic             s_fire, m_fire;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [31:0]      beat_cnt_q, beat_cnt_d;

    assign s_fire = s_axis_tvalid && s_axis_tready;
    assign m_fire = m_axis_tvalid && m_axis_tready;

    // With no stages both fires coincide, so the count stays at zero.
    always_comb begin
        occ_d = occ_q;
        if (s_fire && !m_fire)      occ_d = occ_q + OCC_W'(1);
        else if (m_fire && !s_fire) occ_d = occ_q - OCC_W'(1);
        beat_cnt_d = beat_cnt_q + 32'(m_fire);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            occ_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            occ_q      <= occ_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign occupancy = occ_q;
    assign beat_cnt  = beat_cnt_q;
`endif

endmodule

// File: tb/tb_axis_reg_array_param.sv
// Bench: FULL N=2 and FWD N=3 instances behind one selectable stimulus port,
// checked against a queue model of an in-order, bounded-capacity pipe.
module tb_axis_reg_array_param;
  import lynxTypes::*;

  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int IW = 4;
  localparam int PW = DW + KW + 1 + IW;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic          areset = 1'b1;
  logic          sel = 1'b0;
  logic          s_valid = 1'b0, m_ready = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [KW-1:0] s_keep = '0;
  logic          s_last = 1'b0;
  logic [IW-1:0] s_id = '0;

  logic          fu_s_ready, fu_m_valid, fu_m_last, fw_s_ready, fw_m_valid, fw_m_last;
  logic [DW-1:0] fu_m_data, fw_m_data;
  logic [KW-1:0] fu_m_keep, fw_m_keep;
  logic [IW-1:0] fu_m_id, fw_m_id;
  logic          o_s_ready, o_m_valid;
  logic [PW-1:0] o_pl, s_pl;
`ifdef REG_ARRAY_STATS_EN
  logic [2:0]    fu_occ, fw_occ, o_occ;
  logic [31:0]   fu_bc, fw_bc, o_bc;
  assign o_occ = sel ? fw_occ : fu_occ;
  assign o_bc  = sel ? fw_bc : fu_bc;
`endif

  assign s_pl      = {s_data, s_keep, s_last, s_id};
  assign o_s_ready = sel ? fw_s_ready : fu_s_ready;
  assign o_m_valid = sel ? fw_m_valid : fu_m_valid;
  assign o_pl      = sel ? {fw_m_data, fw_m_keep, fw_m_last, fw_m_id}
                         : {fu_m_data, fu_m_keep, fu_m_last, fu_m_id};

  axis_reg_array_param #(.N_STAGES(2), .DATA_BITS(DW), .ID_BITS(IW), .MODE(REG_MODE_FULL)) dut_full (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_valid && !sel), .s_axis_tready(fu_s_ready),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tlast(s_last), .s_axis_tid(s_id),
    .m_axis_tvalid(fu_m_valid), .m_axis_tready(m_ready && !sel),
    .m_axis_tdata(fu_m_data), .m_axis_tkeep(fu_m_keep), .m_axis_tlast(fu_m_last), .m_axis_tid(fu_m_id)
`ifdef REG_ARRAY_STATS_EN
    , .occupancy(fu_occ), .beat_cnt(fu_bc)
`endif
  );

  axis_reg_array_param #(.N_STAGES(3), .DATA_BITS(DW), .ID_BITS(IW), .MODE(REG_MODE_FWD)) dut_fwd (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_valid && sel), .s_axis_tready(fw_s_ready),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tlast(s_last), .s_axis_tid(s_id),
    .m_axis_tvalid(fw_m_valid), .m_axis_tready(m_ready && sel),
    .m_axis_tdata(fw_m_data), .m_axis_tkeep(fw_m_keep), .m_axis_tlast(fw_m_last), .m_axis_tid(fw_m_id)
`ifdef REG_ARRAY_STATS_EN
    , .occupancy(fw_occ), .beat_cnt(fw_bc)
`endif
  );

  int            checks = 0, errors = 0, cyc = 0;
  int            n_acc, n_out, first_acc, first_out, last_out;
  logic [PW-1:0] q[$];
  logic [31:0]   exp_bc;
  logic          prev_mv = 1'b0, prev_mr = 1'b0;
  logic [PW-1:0] prev_pl;
  logic          smp_s_ready, smp_s_fire = 1'b0, smp_m_fire;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_beat(input logic [DW-1:0] d);
    s_data  = d;
    s_keep  = KW'($urandom);
    s_last  = 1'($urandom);
    s_id    = IW'($urandom);
    s_valid = 1'b1;
  endtask

  // One clock: observe at the falling edge, update the model, return at posedge+1.
  task automatic cycle();
    logic [PW-1:0] exp_pl;
    @(negedge aclk);
    cyc++;
    smp_s_ready = o_s_ready;
    smp_s_fire  = s_valid && o_s_ready;
    smp_m_fire  = o_m_valid && m_ready;
    if (!areset) begin
`ifdef REG_ARRAY_STATS_EN
      chk("occupancy", int'(o_occ), q.size());
      chk("beat_cnt", o_bc, exp_bc);
`endif
      if (prev_mv && !prev_mr) begin
        chk("hold_valid", o_m_valid, 1'b1);
        chk("hold_payload", o_pl, prev_pl);
      end
      if (q.size() == 0) chk("no_spurious", o_m_valid, 1'b0);
      else if (smp_m_fire) begin
        exp_pl = q.pop_front();
        chk("payload", o_pl, exp_pl);
        n_out++;
        exp_bc++;
        last_out = cyc;
      end
      if (o_m_valid && first_out < 0) first_out = cyc;
      if (smp_s_fire) begin
        q.push_back(s_pl);
        n_acc++;
        if (first_acc < 0) first_acc = cyc;
      end
      prev_mv = o_m_valid;
      prev_mr = m_ready;
      prev_pl = o_pl;
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset(input logic beat_during);
    areset  = 1'b1;
    m_ready = 1'b0;
    if (beat_during) new_beat(64'hDEAD_BEEF_0BAD_F00D);
    else s_valid = 1'b0;
    @(posedge aclk);
    #1;
    @(negedge aclk);
    chk("rst_m_valid", o_m_valid, 1'b0);
    chk("rst_s_ready", o_s_ready, 1'b0);
`ifdef REG_ARRAY_STATS_EN
    chk("rst_occupancy", o_occ, 3'd0);
    chk("rst_beat_cnt", o_bc, 32'd0);
`endif
    @(posedge aclk);
    #1;
    areset  = 1'b0;
    s_valid = 1'b0;
    q.delete();
    n_acc = 0; n_out = 0; first_acc = -1; first_out = -1; last_out = -1;
    exp_bc = '0; prev_mv = 1'b0;
    cycle();
    cycle();
    chk("ready_after_reset", smp_s_ready, 1'b1);
  endtask

  task automatic send(input logic [DW-1:0] d);
    int k = 0;
    new_beat(d);
    do begin
      cycle();
      k++;
    end while (!smp_s_fire && k < 50);
    chk("send_accepted", smp_s_fire, 1'b1);
    s_valid = 1'b0;
  endtask

  task automatic run_random(input int nb);
    int sent = 0, guard = 0;
    s_valid = 1'b0;
    while (n_out < nb && guard < 20000) begin
      if (!s_valid || smp_s_fire) begin
        if (sent < nb && $urandom_range(0, 9) < 7) begin
          new_beat({$urandom, $urandom});
          sent++;
        end else s_valid = 1'b0;
      end
      m_ready = 1'($urandom_range(0, 1));
      cycle();
      guard++;
    end
    s_valid = 1'b0;
    chk("rand_all_out", n_out, nb);
    chk("rand_drained", q.size(), 0);
  endtask

  initial begin
    sel = 1'b0;
    do_reset(1'b1);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      new_beat(64'(i));
      cycle();
      chk("b2b_accept", smp_s_fire, 1'b1);
    end
    s_valid = 1'b0;
    repeat (6) cycle();
    chk("b2b_out", n_out, 8);
    chk("full_latency", (first_out - first_acc), 2);
    chk("gap_free", (last_out - first_out), 7);
`ifdef REG_ARRAY_STATS_EN
    chk("beat_cnt_8", o_bc, 32'd8);
`endif

    do_reset(1'b0);
    new_beat(64'd100);
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (smp_s_fire) new_beat(64'(101 + i));
    end
    chk("full_cap", n_acc, 4);
    chk("full_ready_low", smp_s_ready, 1'b0);
`ifdef REG_ARRAY_STATS_EN
    chk("full_occ_4", o_occ, 3'd4);
`endif
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (8) cycle();
    chk("full_drain", n_out, 4);

    do_reset(1'b0);
    run_random(1000);

    do_reset(1'b0);
    new_beat(64'd1);
    for (int i = 0; i < 20 && n_acc < 3; i++) begin
      cycle();
      if (smp_s_fire) new_beat(64'(1 + n_acc));
    end
    s_valid = 1'b0;
    chk("pre_reset_acc", n_acc, 3);
`ifdef REG_ARRAY_STATS_EN
    chk("pre_reset_occ", o_occ, 3'd3);
`endif
    do_reset(1'b0);
    m_ready = 1'b1;
    send(64'hA);
    send(64'hB);
    repeat (5) cycle();
    chk("post_reset_out", n_out, 2);

`ifdef REG_ARRAY_STATS_EN
    force dut_full.beat_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut_full.beat_cnt_q;
    exp_bc = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) send(64'(16 + i));
    repeat (5) cycle();
    chk("beat_cnt_wrap", o_bc, 32'd1);
`endif

    sel = 1'b1;
    do_reset(1'b0);
    new_beat(64'd200);
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (smp_s_fire) new_beat(64'(201 + i));
    end
    s_valid = 1'b0;
    chk("fwd_cap", n_acc, 3);
    chk("fwd_ready_low", smp_s_ready, 1'b0);
    m_ready = 1'b1;
    cycle();
    chk("fwd_ready_same_cycle", smp_s_ready, 1'b1);
    chk("fwd_first_out", smp_m_fire, 1'b1);
    repeat (4) cycle();
    chk("fwd_drain", n_out, 3);
    chk("fwd_latency", (first_out - first_acc), 3);

    do_reset(1'b0);
    run_random(1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_reg_array_param.md
AXIS_REG_ARRAY_PARAM -- requirements
Module: axis_reg_array_param

Interface
REQ-001 SHALL have parameter N_STAGES, default 2: number of cascaded slices, 0..16; 0 means pure wire.
REQ-002 SHALL have parameter DATA_BITS, default 512: tdata width, multiple of 8.
REQ-003 SHALL have parameter ID_BITS, default 6: tid width, minimum 1.
REQ-004 SHALL have parameter MODE, default REG_MODE_FULL: REG_MODE_FULL is a skid slice with registered tready; REG_MODE_FWD is a forward-only slice.
REQ-005 SHALL have port aclk, input, 1 bit: single clock; all logic is synchronous to its rising edge.
REQ-006 SHALL have port areset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have ports s_axis_tvalid/tready/tdata/tkeep/tlast/tid: slave stream with widths 1/1/DATA_BITS/DATA_BITS/8/1/ID_BITS; tready is the only output.
REQ-008 SHALL have ports m_axis_tvalid/tready/tdata/tkeep/tlast/tid: master stream with the same widths; tready is the only input.
REQ-009 SHALL have port occupancy, output, $clog2(2*N_STAGES+1) bits: beats currently held in the chain (present only with the macro in REQ-028).
REQ-010 SHALL have port beat_cnt, output, 32 bits: beats transferred out of m_axis (present only with the macro in REQ-028).

Function
REQ-011 A transfer SHALL occur on a rising edge where tvalid and tready are both high.
REQ-012 Beats SHALL leave in order, with tdata/tkeep/tlast/tid unmodified.
REQ-013 Latency from s_axis transfer to m_axis_tvalid on an empty chain SHALL be exactly N_STAGES cycles.
REQ-014 Steady-state throughput SHALL be 1 beat/cycle in both modes.
REQ-015 FULL stage: two entries (main + skid); s_tready SHALL be a flop output, low only when the skid entry is occupied.
REQ-016 FULL stage, when the output stalls with main full and an input beat accepted, that beat SHALL go to skid; no beat is ever dropped.
REQ-017 FULL stage, skid SHALL drain into main on the first cycle the downstream consumes main; s_tready SHALL reassert the following cycle.
REQ-018 FWD stage: one entry; s_tready = !valid || m_tready, combinational; capacity 1.
REQ-019 Once m_axis_tvalid is asserted, it and its payload SHALL be held stable until accepted (AXI-Stream rule).
REQ-020 Simultaneous accept and output in the same stage SHALL keep occupancy constant and preserve order.
REQ-021 N_STAGES=0 SHALL connect s to m combinationally, with occupancy tied to 0.
REQ-022 Capacity SHALL be 2*N_STAGES beats (FULL) or N_STAGES beats (FWD).

Reset
REQ-023 While areset is high, all stage valid bits SHALL be 0, m_axis_tvalid 0, s_axis_tready 0, occupancy 0 and beat_cnt 0.
REQ-024 s_axis_tready SHALL go to 1 on the first edge after areset deasserts.
REQ-025 Reset mid-stream SHALL discard all held beats without emitting partial data; payload flops are not reset.
REQ-026 A beat presented during the reset cycle SHALL NOT be accepted.

Configuration
REQ-027 occupancy and beat_cnt SHALL be compiled in only when REG_ARRAY_STATS_EN is defined.
REQ-028 With REG_ARRAY_STATS_EN defined: occupancy is +1 per s transfer and -1 per m transfer (same cycle: unchanged); beat_cnt is +1 per m transfer and wraps 0xFFFFFFFF to 0.
REQ-029 Without REG_ARRAY_STATS_EN: both ports and counters are absent; datapath behaviour is identical.

Structure
REQ-030 Enum reg_mode_t {REG_MODE_FULL, REG_MODE_FWD} SHALL live in lynxTypes.
REQ-031 One sub-module, axis_reg_slice_param (one stage, MODE-selected), SHALL be instantiated N_STAGES times through a generate loop.

Verification
REQ-032 FULL, N=2, m_tready=1, 8 back-to-back beats 0..7: m outputs 0..7 starting 2 cycles after the first accept, gap-free; beat_cnt=8.
REQ-033 FULL, N=2, m_tready=0, s_tvalid held: exactly 4 beats accepted; s_tready low from then on; occupancy=4.
REQ-034 FWD, N=3, m_tready=0: 3 beats accepted; m_tready raised gives 3 beats in order with s_tready=1 in that same cycle.
REQ-035 Random m_tready (50%), 1000 beats with random tlast/tid: scoreboard exact match; tvalid/payload stable while stalled.
REQ-036 areset pulsed with occupancy=3: next cycle occupancy=0 and m_tvalid=0; new beats 0xA,0xB emerge with no old data.
REQ-037 beat_cnt preloaded to 0xFFFFFFFE by force, then 3 beats: beat_cnt=1.
